uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Dedicated clocked UART receiver: serial line in, parallel byte out. It is the receive end for frames produced by the uart_module transmitter.
- Recovers 8N1 frames by default, with optional parity, using mid-bit 3-sample majority voting.
- Sits between the pad-side rx wire and the byte consumer, and reports framing and parity errors.
- Default timing is 1 MHz clk at 9600 baud: a 104-cycle bit, matching the 104 us bit time used in existing benches.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit; legal range 8..65535.
- DATA_BITS, 8, payload bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line; idle high; asynchronous to clk.
- dout  out  8  last received payload, LSB-aligned; upper bits are 0 when DATA_BITS<8.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  framing error (stop bit sampled 0) for the last frame.
- parity_err  out  1  parity mismatch for the last frame; always 0 when PARITY=0.
- busy  out  1  high whenever the state is not IDLE.
- brk  out  1  break-condition indicator (see Optional Feature).

Behaviour:
- Reset values: dout=0, done=0, err=0, parity_err=0, busy=0, brk=0. The rx synchronizer flops reset to 1. State resets to IDLE. The bit counter and sample counter reset to 0.
- Reset mid-frame: everything clears immediately; the partial frame is discarded with no done pulse.
- Synchronization: rx passes through a 2-flop synchronizer giving rxs. All decisions use rxs.
- Sampling: the bit-time counter cnt runs 0..CLKS_PER_BIT-1. Define M=CLKS_PER_BIT/2 (integer). Samples are taken at cnt=M-1, M and M+1. The bit value is the 2-of-3 majority, resolved at cnt=M+1.
- States: IDLE, START, DATA, PAR, STOP, WAIT_HI.
- IDLE: a high-to-low transition on rxs moves to START with cnt=0.
- START: if the majority is 1, this is a false start. Return to IDLE with no outputs changed. Otherwise, at cnt=CLKS_PER_BIT-1, move to DATA.
- DATA: shift in LSB first, DATA_BITS bits. After the last bit's end, move to PAR if PARITY!=0, else to STOP.
- PAR: sample the parity bit. parity_err_next = (XOR of data ^ parity bit) != (PARITY==2).
- STOP: at the majority decision (cnt=M+1), on the next edge:
  - done=1 for exactly one cycle;
  - dout, err and parity_err are loaded;
  - err = ~majority.
- After STOP:
  - If the stop bit was 1, go to IDLE immediately, giving half a bit of slack to catch a back-to-back start bit.
  - If the stop bit was 0, go to WAIT_HI and stay until rxs=1, then go to IDLE. The held-low line must not be re-detected as a start.
- Output holding: dout, err and parity_err hold until the next done. done is never asserted for a false start.
- Latency: done rises (DATA_BITS+1+(PARITY!=0))*CLKS_PER_BIT + M+2 cycles after the first clk edge that sees rx low, plus 2 cycles for synchronization.
- Glitches: a single-cycle glitch on rx during any sample window is outvoted by the majority.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined: brk is set on the same cycle as done when all data bits, the parity bit (if present) and the stop bit were all 0. brk stays high until rxs returns to 1, then clears on the next edge. err is also 1 for that frame.
- Undefined: brk is tied to 0 and no break logic is synthesized.

Test Plan:
- Use CLKS_PER_BIT=16 for simulation speed.
- 8N1 frame of 8'd120 (0x78) with a correct stop bit -> one done pulse, dout=0x78, err=0, parity_err=0, busy=0 one cycle after done.
- Back-to-back frames 8'd240 then 8'd22 with no idle gap -> two done pulses 10*16 cycles apart, dout=0xF0 then 0x16, err=0 both times.
- Frame 8'd44 with the stop bit forced 0 and rx held low for 3 more bits, then high -> done with err=1, state WAIT_HI, no second done; a following 0x2C frame is received correctly.
- PARITY=1 (even), send 0x78 with parity bit 1 (wrong) -> parity_err=1, dout=0x78. Resend with parity 0 -> parity_err=0.
- False start (rx low for 4 cycles only) and a 1-cycle glitch inside bit 3 of 0x78 -> no done for the false start; the glitched frame still gives dout=0x78. Then assert rst_n=0 mid-frame -> all outputs 0 immediately, no done.
- With UART_RX_BREAK_DET_EN defined, hold rx low for 12 bit times -> done with err=1 and brk=1; brk clears 3 cycles after rx goes high. With the macro undefined, brk stays 0.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronized rx, mid-bit 3-sample majority vote, optional parity.
// Define UART_RX_BREAK_DET_EN to build the break-condition detector on brk.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       done,
  output logic       err,
  output logic       parity_err,
  output logic       busy,
  output logic       brk
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int M  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_S0   = CW'(M - 1);
  localparam logic [CW-1:0] C_S1   = CW'(M);
  localparam logic [CW-1:0] C_S2   = CW'(M + 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PAR     = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      data;
  logic            rx_meta, rxs, rxs_d;
  logic            s0, s1;
  logic            par_err_n;
  logic            vote;
  logic            cnt_end;

  assign vote    = maj3(s0, s1, rxs);
  assign cnt_end = (cnt == C_LAST);

  // stage: rx synchronizer (idles high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // stage: sample and payload capture (data path, no reset)
  always_ff @(posedge clk) begin
    if (cnt == C_S0) s0 <= rxs;
    if (cnt == C_S1) s1 <= rxs;
    if (state == IDLE)
      data <= '0;
    else if (state == DATA && cnt == C_S2)
      data[bit_idx] <= vote;
  end

  // stage: frame FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      par_err_n  <= 1'b0;
      dout       <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (rxs_d && !rxs) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == C_S2 && vote) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt_end) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt_end) begin
            cnt <= '0;
            if (bit_idx == LAST_BIT)
              state <= (PARITY != 0) ? PAR : STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAR: begin
          if (cnt == C_S2)
            par_err_n <= ((^data) ^ vote) != PAR_ODD;
          if (cnt_end) begin
            state <= STOP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid-bit so a back-to-back start edge is not missed.
          if (cnt == C_S2) begin
            done       <= 1'b1;
            dout       <= data;
            err        <= ~vote;
            parity_err <= (PARITY != 0) && par_err_n;
            state      <= vote ? IDLE : WAIT_HI;
            busy       <= ~vote;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic all_zero;

  // stage: break detection (all payload, parity and stop bits low)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_zero <= 1'b0;
      brk      <= 1'b0;
    end else begin
      if (state == IDLE)
        all_zero <= 1'b1;
      else if ((state == DATA || state == PAR) && cnt == C_S2 && vote)
        all_zero <= 1'b0;
      if (state == STOP && cnt == C_S2)
        brk <= all_zero & ~vote;
      else if (rxs)
        brk <= 1'b0;
    end
  end
`else
  assign brk = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at 16 clocks per bit: 8N1 instance plus an even-parity instance.
module tb_uart_rx_core;
  localparam int CPB = 16;

`ifdef UART_RX_BREAK_DET_EN
  localparam logic BRK_ON = 1'b1;
`else
  localparam logic BRK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic [7:0] dout, dout_p;
  logic       done, err, parity_err, busy, brk;
  logic       done_p, err_p, parity_err_p, busy_p, brk_p;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
    logic       p;
    logic       b;
  } rec_t;

  rec_t exp_q[$], got_q[$], expp_q[$], gotp_q[$];
  int   got_t[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .dout(dout), .done(done), .err(err),
    .parity_err(parity_err), .busy(busy), .brk(brk)
  );

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1)) u_par (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .dout(dout_p), .done(done_p), .err(err_p),
    .parity_err(parity_err_p), .busy(busy_p), .brk(brk_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      got_q.push_back({dout, err, parity_err, brk});
      got_t.push_back(cyc);
    end
    if (done_p) gotp_q.push_back({dout_p, err_p, parity_err_p, brk_p});
  end

  task automatic hold_bit(input logic b, input bit sel);
    if (sel) rx_p = b;
    else     rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Pushes the expected record, then drives start, 8 data bits LSB first, [parity], stop.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop, input logic pbit);
    if (sel)
      expp_q.push_back({d, ~stop, logic'((^d) ^ pbit), 1'b0});
    else
      exp_q.push_back({d, ~stop, 1'b0, logic'(BRK_ON && d == 8'h00 && !stop)});
    hold_bit(1'b0, sel);
    for (int i = 0; i < 8; i++) hold_bit(d[i], sel);
    if (sel) hold_bit(pbit, sel);
    hold_bit(stop, sel);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    rx_p = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({dout, done, err, parity_err, busy, brk} !== 13'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b required=0", {dout, done, err, parity_err, busy, brk});
    end
    total++;
    if ({dout_p, done_p, err_p, parity_err_p, busy_p, brk_p} !== 13'b0) begin
      bad++;
      $display("FAIL reset_outs_par got=%b required=0", {dout_p, done_p, err_p, parity_err_p, busy_p, brk_p});
    end
    rst_n = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    total++;
    if ({done, busy, err} !== 3'b0 || got_q.size() != 0) begin
      bad++;
      $display("FAIL reset_idle got=%b dones=%0d required=000/0", {done, busy, err}, got_q.size());
    end
  endtask

  task automatic test_frame_8n1();
    int   t0;
    bit   seen;
    rec_t g, e;
    t0 = cyc;
    seen = 1'b0;
    fork
      send_frame(1'b0, 8'd120, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (done) begin
            seen = 1'b1;
            break;
          end
        end
        total++;
        if (!seen) begin
          bad++;
          $display("FAIL 8n1_timeout got=no_done required=done");
        end else begin
          total++;
          if (cyc != t0 + 157) begin
            bad++;
            $display("FAIL 8n1_latency got=%0d required=%0d", cyc - t0, 157);
          end
          @(negedge clk);
          total++;
          if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL 8n1_after_done got=done%b busy%b required=00", done, busy);
          end
        end
      end
    join
    repeat (CPB) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL 8n1_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL 8n1_rec got=%h/%b/%b/%b required=%h/%b/%b/%b", g.d, g.e, g.p, g.b, e.d, e.e, e.p, e.b);
      end
    end
    got_q.delete(); exp_q.delete(); got_t.delete();
  endtask

  task automatic test_back_to_back();
    rec_t g, e;
    send_frame(1'b0, 8'd240, 1'b1, 1'b0);
    send_frame(1'b0, 8'd22, 1'b1, 1'b0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    total++;
    if (got_t.size() != 2 || got_t[1] - got_t[0] != 10 * CPB) begin
      bad++;
      $display("FAIL b2b_spacing got=%0d pulses gap=%0d required=2 pulses gap=%0d", got_t.size(),
               (got_t.size() == 2) ? got_t[1] - got_t[0] : -1, 10 * CPB);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL b2b_rec got=%h/%b/%b/%b required=%h/%b/%b/%b", g.d, g.e, g.p, g.b, e.d, e.e, e.p, e.b);
      end
    end
    got_q.delete(); exp_q.delete(); got_t.delete();
  endtask

  task automatic test_stop_err();
    rec_t g, e;
    send_frame(1'b0, 8'd44, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) hold_bit(1'b0, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL stoperr_wait_hi got=busy%b required=busy1", busy);
    end
    hold_bit(1'b1, 1'b0);
    hold_bit(1'b1, 1'b0);
    total++;
    if (got_q.size() != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stoperr_single_done got=%0d busy%b required=1 busy0", got_q.size(), busy);
    end
    send_frame(1'b0, 8'h2C, 1'b1, 1'b0);
    repeat (CPB) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL stoperr_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL stoperr_rec got=%h/%b/%b/%b required=%h/%b/%b/%b", g.d, g.e, g.p, g.b, e.d, e.e, e.p, e.b);
      end
    end
    got_q.delete(); exp_q.delete(); got_t.delete();
  endtask

  task automatic test_parity();
    rec_t g, e;
    send_frame(1'b1, 8'h78, 1'b1, 1'b1);
    send_frame(1'b1, 8'h78, 1'b1, 1'b0);
    send_frame(1'b1, 8'h2C, 1'b1, 1'b1);
    send_frame(1'b1, 8'h2C, 1'b1, 1'b0);
    repeat (CPB) @(posedge clk);
    #1;
    total++;
    if (gotp_q.size() != expp_q.size()) begin
      bad++;
      $display("FAIL parity_count got=%0d required=%0d", gotp_q.size(), expp_q.size());
    end
    while (gotp_q.size() > 0 && expp_q.size() > 0) begin
      g = gotp_q.pop_front();
      e = expp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL parity_rec got=%h/%b/%b/%b required=%h/%b/%b/%b", g.d, g.e, g.p, g.b, e.d, e.e, e.p, e.b);
      end
    end
    gotp_q.delete(); expp_q.delete();
  endtask

  task automatic test_false_start_glitch();
    rec_t       g, e;
    logic [7:0] d;
    d = 8'h78;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL false_start got=%0d dones busy%b required=0 dones busy0", got_q.size(), busy);
    end
    exp_q.push_back({d, 1'b0, 1'b0, 1'b0});
    hold_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        // one inverted cycle right at the middle sample of bit 3
        rx = d[i];
        repeat (9) @(posedge clk);
        #1 rx = ~d[i];
        @(posedge clk);
        #1 rx = d[i];
        repeat (6) @(posedge clk);
        #1;
      end else begin
        hold_bit(d[i], 1'b0);
      end
    end
    hold_bit(1'b1, 1'b0);
    repeat (CPB) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL glitch_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL glitch_rec got=%h/%b/%b/%b required=%h/%b/%b/%b", g.d, g.e, g.p, g.b, e.d, e.e, e.p, e.b);
      end
    end
    got_q.delete(); exp_q.delete(); got_t.delete();
  endtask

  task automatic test_reset_midframe();
    hold_bit(1'b0, 1'b0);
    hold_bit(1'b1, 1'b0);
    hold_bit(1'b0, 1'b0);
    total++;
    if (busy !== 1'b1 || dout !== 8'h78) begin
      bad++;
      $display("FAIL midreset_pre got=busy%b dout=%h required=busy1 dout=78", busy, dout);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({dout, done, err, parity_err, busy, brk} !== 13'b0 || dout_p !== 8'h00) begin
      bad++;
      $display("FAIL midreset_clear got=%b dout_p=%h required=0", {dout, done, err, parity_err, busy, brk}, dout_p);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_no_done got=%0d dones busy%b required=0 dones busy0", got_q.size(), busy);
    end
    got_q.delete(); got_t.delete();
  endtask

  task automatic test_break();
    rec_t g, e;
    exp_q.push_back({8'h00, 1'b1, 1'b0, BRK_ON});
    rx = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    #1;
    total++;
    if (brk !== BRK_ON || busy !== 1'b1) begin
      bad++;
      $display("FAIL break_held got=brk%b busy%b required=brk%b busy1", brk, busy, BRK_ON);
    end
    rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (brk !== BRK_ON) begin
      bad++;
      $display("FAIL break_hold_after_rise got=%b required=%b", brk, BRK_ON);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (brk !== 1'b0) begin
      bad++;
      $display("FAIL break_clear got=%b required=0", brk);
    end
    repeat (CPB) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL break_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL break_rec got=%h/%b/%b/%b required=%h/%b/%b/%b", g.d, g.e, g.p, g.b, e.d, e.e, e.p, e.b);
      end
    end
    got_q.delete(); exp_q.delete(); got_t.delete();
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_frame_8n1();
    test_back_to_back();
    test_stop_err();
    test_parity();
    test_false_start_glitch();
    test_reset_midframe();
    test_break();
    total++;
    if (gotp_q.size() != 0) begin
      bad++;
      $display("FAIL par_stray_done got=%0d required=0", gotp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
